// File: rtl/rtype_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rtype_mc_sequencer
// Brief    : Multi-cycle fetch/decode/exec/writeback sequencer for R-type add/sub.
// Revision : 1.0
// ============================================================================
module rtype_mc_sequencer #(
  parameter int PC_W     = 8,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [7:0]          imem_rdata,
  input  logic                imem_valid,
  output logic [4:0]          rf_ra1,
  output logic [4:0]          rf_ra2,
  input  logic [31:0]         rf_rd1,
  input  logic [31:0]         rf_rd2,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [3:0]          alu_op,
  input  logic [31:0]         alu_result,
  output logic                rf_we,
  output logic [4:0]          rf_wa,
  output logic [31:0]         rf_wd,
  output logic [PC_W-1:0]     pc,
  output logic [31:0]         instr,
  output logic                busy,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_f7_add   = 7'b0000000;
  localparam logic [6:0] c_f7_sub   = 7'b0100000;
  localparam logic [3:0] c_alu_add  = 4'b0010;
  localparam logic [3:0] c_alu_sub  = 4'b0110;
  localparam logic [3:0] c_alu_none = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t                r_state;
  logic [PC_W-1:0]       r_pc;
  logic [31:0]           r_instr;
  logic [1:0]            r_byte_idx;
  logic [31:0]           r_alu_a;
  logic [31:0]           r_alu_b;
  logic [3:0]            r_alu_op;
  logic                  r_legal;
  logic                  r_rf_we;
  logic [4:0]            r_rf_wa;
  logic [31:0]           r_rf_wd;
  logic                  r_illegal;
  logic [RETIRE_W-1:0]   r_retire_cnt;

  logic                  w_is_rtype;
  logic                  w_is_add;
  logic                  w_is_sub;

  assign w_is_rtype = (r_instr[6:0] == c_op_rtype) && (r_instr[14:12] == 3'b000);
  assign w_is_add   = w_is_rtype && (r_instr[31:25] == c_f7_add);
  assign w_is_sub   = w_is_rtype && (r_instr[31:25] == c_f7_sub);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_instr      <= '0;
      r_byte_idx   <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= c_alu_none;
      r_legal      <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_wa      <= '0;
      r_rf_wd      <= '0;
      r_illegal    <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      // Write and illegal strobes are armed on the EXEC->WB edge only.
      r_rf_we   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state    <= S_FETCH;
            r_byte_idx <= '0;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            r_instr[{r_byte_idx, 3'b000} +: 8] <= imem_rdata;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state <= S_DECODE;
            end
          end
        end
        S_DECODE: begin
          r_legal  <= w_is_add || w_is_sub;
          r_alu_op <= w_is_add ? c_alu_add : (w_is_sub ? c_alu_sub : c_alu_none);
          r_alu_a  <= rf_rd1;
          r_alu_b  <= rf_rd2;
          r_rf_wa  <= r_instr[11:7];
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          r_rf_wd   <= r_legal ? alu_result : 32'h0;
          r_rf_we   <= r_legal && (r_rf_wa != 5'd0);
          r_illegal <= !r_legal;
          r_state   <= S_WB;
        end
        S_WB: begin
          r_pc         <= r_pc + PC_W'(4);
          r_retire_cnt <= r_retire_cnt + RETIRE_W'(1);
          r_byte_idx   <= '0;
          r_state      <= en ? S_FETCH : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc + PC_W'(r_byte_idx);
  assign rf_ra1     = r_instr[19:15];
  assign rf_ra2     = r_instr[24:20];
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rf_we      = r_rf_we;
  assign rf_wa      = r_rf_wa;
  assign rf_wd      = r_rf_wd;
  assign pc         = r_pc;
  assign instr      = r_instr;
  assign busy       = (r_state != S_IDLE);
  assign illegal    = r_illegal;
  assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire
